// File: rtl/nes_pad_responder.sv
// NES controller emulator: answers the console's latch/pulse protocol with a button snapshot.
// Latch and pulse are asynchronous to clk and are synchronized before edge detection.
module nes_pad_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_latch,
  input  logic       nes_pulse,
  input  logic [7:0] buttons,
  output logic       nes_data,
  output logic [7:0] latched,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  logic [SYNC_STAGES-1:0] latch_sync_q;
  logic [SYNC_STAGES-1:0] pulse_sync_q;
  logic                   latch_prev_q;
  logic                   pulse_prev_q;
  logic                   latch_s;
  logic                   pulse_s;
  logic                   latch_fall;
  logic                   pulse_rise;

  state_e      state_q;
  logic [7:0]  sreg_q;
  logic [3:0]  cnt_q;
  logic        nes_data_q;
  logic [7:0]  latched_q;
  logic        busy_q;
  logic        frame_done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_sync_q <= '0;
      pulse_sync_q <= '0;
      latch_prev_q <= 1'b0;
      pulse_prev_q <= 1'b0;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], nes_latch};
      pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], nes_pulse};
      latch_prev_q <= latch_sync_q[SYNC_STAGES-1];
      pulse_prev_q <= pulse_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    latch_s    = latch_sync_q[SYNC_STAGES-1];
    pulse_s    = pulse_sync_q[SYNC_STAGES-1];
    latch_fall = ~latch_s & latch_prev_q;
    pulse_rise = pulse_s & ~pulse_prev_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      sreg_q       <= 8'hFF;
      cnt_q        <= 4'd0;
      nes_data_q   <= 1'b1;
      latched_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      nes_data_q   <= sreg_q[0];
      unique case (state_q)
        StIdle: begin
          if (latch_s) state_q <= StLoad;
        end
        StLoad: begin
          // Transparent load; pulse edges are ignored, including one coincident with the fall.
          sreg_q <= ~buttons;
          if (latch_fall) begin
            state_q   <= StShift;
            latched_q <= buttons;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b1;
          end
        end
        StShift: begin
          // Latch in SHIFT can only be a new rising edge: abort, and it beats any pulse.
          if (latch_s) begin
            state_q <= StLoad;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
          end else if (pulse_rise) begin
            sreg_q <= {1'b0, sreg_q[7:1]};
            if (cnt_q == 4'd7) begin
              cnt_q        <= 4'd8;
              state_q      <= StDone;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        StDone: begin
          if (latch_s) begin
            state_q <= StLoad;
            cnt_q   <= 4'd0;
          end else if (pulse_rise) begin
            sreg_q <= {1'b0, sreg_q[7:1]};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign nes_data   = nes_data_q;
  assign latched    = latched_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Scoreboard bench for nes_pad_responder: stimulus queues expectations with a due cycle,
// a negedge monitor pops and compares them and counts frame_done pulses.
module tb_nes_pad_responder;

  localparam int unsigned SYNC = 2;
  localparam int          LAT  = SYNC + 2;

  localparam int KData  = 0;
  localparam int KBusy  = 1;
  localparam int KLatch = 2;
  localparam int KFd    = 3;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
    int         due;
  } item_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       nes_latch = 1'b0;
  logic       nes_pulse = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       nes_data;
  logic [7:0] latched;
  logic       busy;
  logic       frame_done;

  item_t exp_q[$];
  int    cycle = 0;
  int    tests = 0;
  int    fails = 0;
  int    fd_cnt = 0;
  logic  busy_prev = 1'b0;

  nes_pad_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .nes_latch  (nes_latch),
    .nes_pulse  (nes_pulse),
    .buttons    (buttons),
    .nes_data   (nes_data),
    .latched    (latched),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Monitor: counts frame_done cycles and retires every expectation whose due cycle has come.
  initial forever begin
    item_t      it;
    logic [7:0] act;
    @(negedge clk);
    if (frame_done) fd_cnt++;
    if (busy && !busy_prev) begin
      tests++;
      if (frame_done) begin
        fails++;
        $display("FAIL busy_rise_frame_done: got frame_done=1 expected 0 at cycle %0d", cycle);
      end
    end
    busy_prev = busy;
    while (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
      it = exp_q.pop_front();
      case (it.kind)
        KData:   act = {7'b0, nes_data};
        KBusy:   act = {7'b0, busy};
        KLatch:  act = latched;
        default: begin
          act = fd_cnt[7:0];
          fd_cnt = 0;
        end
      endcase
      tests++;
      if (act !== it.exp) begin
        fails++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", it.name, act, it.exp, cycle);
      end
    end
  end

  task automatic push(input string name, input int kind, input logic [7:0] exp, input int due);
    item_t it;
    it.name = name;
    it.kind = kind;
    it.exp  = exp;
    it.due  = due;
    exp_q.push_back(it);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic latch_high();
    wait_cyc(1);
    nes_latch = 1'b1;
    wait_cyc(600);
  endtask

  // Latch fall: expect SHIFT entered, snapshot captured, bit0 presented.
  task automatic latch_low(input string nm, input logic bit0, input logic [7:0] snap);
    wait_cyc(1);
    nes_latch = 1'b0;
    push({nm, "_bit0"}, KData, {7'b0, bit0}, cycle + LAT);
    push({nm, "_busy"}, KBusy, 8'h01, cycle + LAT);
    push({nm, "_latched"}, KLatch, snap, cycle + LAT);
  endtask

  // One 6 us pulse; optionally checks that the old bit is still shown one cycle before the new one.
  task automatic pulse(input string nm, input logic prev, input logic exp, input bit lat);
    wait_cyc(1);
    nes_pulse = 1'b1;
    if (lat) push({nm, "_early"}, KData, {7'b0, prev}, cycle + LAT - 1);
    push(nm, KData, {7'b0, exp}, cycle + LAT);
    wait_cyc(150);
    nes_pulse = 1'b0;
    wait_cyc(149);
  endtask

  initial begin
    int s1[9] = '{0, 1, 1, 0, 1, 1, 1, 1, 0};
    int s2[4] = '{0, 1, 0, 1};
    int s5[6] = '{0, 1, 0, 1, 0, 0};
    int s6[13] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int guard;

    // Reset state
    wait_cyc(5);
    push("rst_data", KData, 8'h01, cycle);
    push("rst_busy", KBusy, 8'h00, cycle);
    push("rst_latched", KLatch, 8'h00, cycle);
    push("rst_fd", KFd, 8'h00, cycle);
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(5);

    // Basic frame: A + Start
    buttons = 8'h09;
    latch_high();
    latch_low("t1", 1'b0, 8'h09);
    for (int i = 1; i <= 8; i++)
      pulse($sformatf("t1_p%0d", i), s1[i-1][0], s1[i][0], 1'b1);
    push("t1_busy_end", KBusy, 8'h00, cycle);
    push("t1_fd", KFd, 8'h01, cycle);

    // Abort after 3 pulses, then a full frame with every button pressed
    buttons = 8'hA5;
    latch_high();
    latch_low("t2a", 1'b0, 8'hA5);
    for (int i = 1; i <= 3; i++)
      pulse($sformatf("t2a_p%0d", i), s2[i-1][0], s2[i][0], 1'b0);
    wait_cyc(1);
    nes_latch = 1'b1;
    buttons = 8'hFF;
    push("t2_abort_busy", KBusy, 8'h00, cycle + LAT);
    wait_cyc(600);
    push("t2_abort_fd", KFd, 8'h00, cycle);
    latch_low("t2b", 1'b0, 8'hFF);
    for (int i = 1; i <= 8; i++)
      pulse($sformatf("t2b_p%0d", i), 1'b0, 1'b0, 1'b0);
    push("t2b_fd", KFd, 8'h01, cycle);

    // Latch fall and pulse rise in the same cycle: A still first, 8 more pulses needed
    buttons = 8'h01;
    latch_high();
    wait_cyc(1);
    nes_latch = 1'b0;
    nes_pulse = 1'b1;
    push("t3_bit0", KData, 8'h00, cycle + LAT);
    push("t3_busy", KBusy, 8'h01, cycle + LAT);
    push("t3_bit0_hold", KData, 8'h00, cycle + LAT + 20);
    wait_cyc(150);
    nes_pulse = 1'b0;
    wait_cyc(149);
    for (int i = 1; i <= 7; i++)
      pulse($sformatf("t3_p%0d", i), (i == 1) ? 1'b0 : 1'b1, 1'b1, 1'b1);
    push("t3_fd_after7", KFd, 8'h00, cycle);
    pulse("t3_p8", 1'b1, 1'b0, 1'b1);
    push("t3_fd_after8", KFd, 8'h01, cycle);

    // Buttons change mid-frame must not disturb it
    buttons = 8'h00;
    latch_high();
    latch_low("t4", 1'b1, 8'h00);
    pulse("t4_p1", 1'b1, 1'b1, 1'b0);
    pulse("t4_p2", 1'b1, 1'b1, 1'b0);
    buttons = 8'hFF;
    for (int i = 3; i <= 7; i++)
      pulse($sformatf("t4_p%0d", i), 1'b1, 1'b1, 1'b0);
    pulse("t4_p8", 1'b1, 1'b0, 1'b0);
    push("t4_latched_end", KLatch, 8'h00, cycle);
    push("t4_fd", KFd, 8'h01, cycle);

    // Reset mid-frame after 5 pulses
    buttons = 8'h75;
    latch_high();
    latch_low("t5", 1'b0, 8'h75);
    for (int i = 1; i <= 5; i++)
      pulse($sformatf("t5_p%0d", i), s5[i-1][0], s5[i][0], 1'b0);
    wait_cyc(1);
    reset = 1'b0;
    push("t5_rst_data", KData, 8'h01, cycle + 1);
    push("t5_rst_busy", KBusy, 8'h00, cycle + 1);
    push("t5_rst_latched", KLatch, 8'h00, cycle + 1);
    push("t5_rst_fd", KFd, 8'h00, cycle + 1);
    wait_cyc(3);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++)
      pulse($sformatf("t5_nolatch_p%0d", i), 1'b1, 1'b1, 1'b0);
    push("t5_nolatch_busy", KBusy, 8'h00, cycle);
    push("t5_nolatch_fd", KFd, 8'h00, cycle);

    // 12 pulses after one latch: single frame_done, zeros from pulse 8 onward
    buttons = 8'h80;
    latch_high();
    latch_low("t6", 1'b1, 8'h80);
    for (int i = 1; i <= 12; i++)
      pulse($sformatf("t6_p%0d", i), s6[i-1][0], s6[i][0], 1'b0);
    push("t6_fd", KFd, 8'h01, cycle);
    push("t6_busy", KBusy, 8'h00, cycle);

    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      wait_cyc(1);
      guard++;
    end
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    wait_cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nes_pad_responder.md
NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on nes_latch and nes_pulse (legal 2..4).
REQ-002 SHALL have port clk  input  1  single system clock (50 MHz); all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 SHALL have port nes_latch  input  1  console latch strobe, asynchronous to clk, active-high.
REQ-005 SHALL have port nes_pulse  input  1  console shift clock, asynchronous to clk; shift on rising edge.
REQ-006 SHALL have port buttons  input  8  pressed=1; bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
REQ-007 SHALL have port nes_data  output  1  serial line to console, active-low (0 = pressed), registered.
REQ-008 SHALL have port latched  output  8  button snapshot (pressed=1) captured at latch falling edge.
REQ-009 SHALL have port busy  output  1  high while a frame is being shifted (state SHIFT).
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when the 8th bit has been shifted past.

Function
REQ-011 SHALL pass nes_latch and nes_pulse each through SYNC_STAGES flops, then one extra flop for edge detection; edges are compared on synchronized values only.
REQ-012 SHALL keep an 8-bit shift register sreg holding line levels (~buttons); nes_data = sreg[0], registered.
REQ-013 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-014 IDLE: nes_data=1; synced latch high -> LOAD.
REQ-015 LOAD: every cycle sreg <= ~buttons (transparent parallel load); pulse edges ignored; synced latch falling edge -> SHIFT, latched <= buttons (value of that cycle), bit count <= 0.
REQ-016 SHIFT: each synced pulse rising edge: sreg <= {1'b0, sreg[7:1]}, count <= count+1; count 7->8 asserts frame_done for exactly one cycle and -> DONE.
REQ-017 DONE: nes_data holds 0 (shifted-in fill); further pulse edges keep nes_data=0, no further frame_done; latch high -> LOAD.
REQ-018 Bit count SHALL be 4 bits, saturating at 8, never wrapping.
REQ-019 Latch rising edge in SHIFT or DONE SHALL abort the frame: -> LOAD, count <= 0, no frame_done, busy deasserts same cycle.
REQ-020 Latch rising and pulse rising detected in the same cycle: latch wins, pulse discarded.
REQ-021 Pulse rising and latch falling detected in the same cycle: enter SHIFT, pulse discarded (bit0 stays presented).
REQ-022 Latency: nes_data SHALL reflect an external edge exactly SYNC_STAGES+2 clk cycles after it (SYNC_STAGES sync + edge flop + output register).
REQ-023 buttons changes during SHIFT SHALL NOT affect the frame in progress.
REQ-024 busy = 1 iff state SHIFT; frame_done registered, never asserted in the cycle busy rises.

Reset
REQ-025 While reset=0: state IDLE, sreg=8'hFF, nes_data=1, latched=8'h00, busy=0, frame_done=0, count=0, sync flops=0.
REQ-026 Reset asserted mid-frame SHALL abort with no frame_done; after release, first action requires a fresh latch high.
REQ-027 Release of reset SHALL be synchronized externally; block needs no extra release logic.

Verification
REQ-028 buttons=8'b0000_1001, latch 12 us high then low, 8 pulses 6 us apart -> nes_data sequence 0,1,1,0,1,1,1,1 then 0; latched=8'h09; one frame_done.
REQ-029 Latch re-raised after 3 pulses -> busy drops, no frame_done, next full frame with buttons=8'hFF yields eight 0s.
REQ-030 Latch falling and pulse rising within same clk cycle -> bit0 (A) still presented first, 8 further pulses required for frame_done.
REQ-031 buttons toggled 8'h00->8'hFF after 2nd pulse -> remaining bits stay 1 (not pressed), latched=8'h00.
REQ-032 reset=0 pulsed after 5th pulse -> nes_data=1, busy=0, frame_done never asserted, outputs at REQ-025 values.
REQ-033 12 pulses after one latch -> exactly one frame_done, nes_data=0 for pulses 9-12.
